// File: rtl/apb_node_pkg.sv
// Shared types for the APB fan-out node: FSM state encoding, the captured
// response record and a small width helper.
package apb_node_pkg;

  // Transfer sequencing states; exposed on the debug output of the top.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } node_state_e;

  // APB data buses are at most 32 bits wide, so the captured read data is
  // held at that width and sliced down to the configured data width.
  localparam int unsigned APB_MAX_DATA_W = 32;

  // Response captured at the end of ACCESS (or forced on decode error /
  // timeout) and replayed to the master during RESP.
  typedef struct packed {
    logic [APB_MAX_DATA_W-1:0] rdata;
    logic                      slverr;
  } apb_resp_t;

  // Width of a slave index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_node_ctrl_if.sv
// Upstream APB link between the bus bridge (master) and the fan-out node.
//
// Handshake: a transfer starts when psel=1 and penable=0 (setup phase); the
// master then holds psel=1, penable=1 until it samples pready=1 on a rising
// edge. pslverr and prdata are only meaningful in that same cycle, and
// prdata is 0 whenever pready is 0.
interface apb_node_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  import apb_node_pkg::*;

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: compares one address against NB_MASTER
// inclusive windows and reports the lowest-index match.
module apb_addr_decoder
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned IDX_W          = idx_width(NB_MASTER)
) (
  input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic [NB_MASTER-1:0]                     onehot_o,
  output logic                                     match_o,
  output logic [IDX_W-1:0]                         idx_o
);

  logic [NB_MASTER-1:0] hit;

  // Window compare per slave, then priority pick scanning high to low so
  // the lowest matching index is the last (winning) assignment.
  always_comb begin
    hit      = '0;
    onehot_o = '0;
    match_o  = 1'b0;
    idx_o    = '0;
    for (int i = 0; i < int'(NB_MASTER); i++) begin
      hit[i] = (paddr_i >= start_addr_i[i]) && (paddr_i <= end_addr_i[i]);
    end
    for (int i = int'(NB_MASTER) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        match_o     = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_ctrl.sv
// Registered APB fan-out node: one upstream master, NB_MASTER slaves.
// Each transfer is latched in IDLE and replayed to the decoded slave through
// SETUP/ACCESS, then answered upstream in a single RESP cycle. Unmapped
// addresses get an immediate error response; a slave that never raises
// pready is aborted after TIMEOUT_CYCLES ACCESS cycles (0 disables this).
module apb_node_ctrl
  import apb_node_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  apb_node_ctrl_if.slave                           up,
  output logic [NB_MASTER-1:0]                     psel_o,
  output logic [NB_MASTER-1:0]                     penable_o,
  output logic [NB_MASTER-1:0]                     pwrite_o,
  output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                     pready_i,
  input  logic [NB_MASTER-1:0]                     pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i,
  output logic                                     decerr_o,
  output logic                                     timeout_o,
  output node_state_e                              state_o
);

  localparam int unsigned IDX_W     = idx_width(NB_MASTER);
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW        = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  // Counter value of the last ACCESS cycle allowed before the abort.
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  node_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NB_MASTER-1:0]       sel_q, sel_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  apb_resp_t                  resp_q, resp_d;
  logic                       decerr_q, decerr_d;
  logic                       timeout_q, timeout_d;

  logic [NB_MASTER-1:0]       dec_onehot;
  logic                       dec_match;
  logic [IDX_W-1:0]           dec_idx;
  logic                       sel_active;

  apb_addr_decoder #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .IDX_W          (IDX_W)
  ) u_dec (
    .paddr_i      (up.paddr),
    .start_addr_i (START_ADDR_i),
    .end_addr_i   (END_ADDR_i),
    .onehot_o     (dec_onehot),
    .match_o      (dec_match),
    .idx_o        (dec_idx)
  );

  // State and latched-transfer registers; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      decerr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      decerr_q  <= decerr_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: upstream inputs are only looked at in IDLE; after
  // that the latched copies drive the slave side.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    decerr_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (up.psel && !up.penable) begin
          addr_d  = up.paddr;
          wdata_d = up.pwdata;
          write_d = up.pwrite;
          idx_d   = dec_idx;
          sel_d   = dec_onehot;
          resp_d  = '0;
          if (dec_match) begin
            state_d = ST_SETUP;
          end else begin
            resp_d.slverr = 1'b1;
            decerr_d      = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i[idx_q]) begin
          resp_d        = '0;
          resp_d.slverr = pslverr_i[idx_q];
          // Read data only travels upstream on a clean read.
          if (!write_q && !pslverr_i[idx_q]) begin
            resp_d.rdata[APB_DATA_WIDTH-1:0] = prdata_i[idx_q];
          end
          state_d = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          resp_d        = '0;
          resp_d.slverr = 1'b1;
          timeout_d     = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  // Slave-side drive: only the latched target sees non-zero signals, and
  // only while the transfer is in SETUP or ACCESS.
  always_comb begin
    psel_o    = '0;
    penable_o = '0;
    pwrite_o  = '0;
    paddr_o   = '0;
    pwdata_o  = '0;
    for (int i = 0; i < int'(NB_MASTER); i++) begin
      if (sel_active && sel_q[i]) begin
        psel_o[i]    = 1'b1;
        penable_o[i] = (state_q == ST_ACCESS);
        pwrite_o[i]  = write_q;
        paddr_o[i]   = addr_q;
        pwdata_o[i]  = wdata_q;
      end
    end
  end

  // Upstream response is decoded purely from registers.
  assign up.pready  = (state_q == ST_RESP);
  assign up.pslverr = (state_q == ST_RESP) && resp_q.slverr;
  assign up.prdata  = (state_q == ST_RESP) ? resp_q.rdata[APB_DATA_WIDTH-1:0] : '0;

  assign decerr_o  = decerr_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_apb_node_ctrl.sv
// Directed bench for apb_node_ctrl: four slaves, 8-cycle timeout. Expected
// upstream responses are queued per transfer and popped by a monitor
// whenever pready_o is seen; per-cycle slave-side behaviour is checked from
// a short history captured by the transfer driver.
module tb_apb_node_ctrl;
  import apb_node_pkg::*;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  apb_node_ctrl_if #(.AW(AW), .DW(DW)) up_if ();

  logic [NB-1:0]         psel_o, penable_o, pwrite_o;
  logic [NB-1:0][AW-1:0] paddr_o, start_addr, end_addr;
  logic [NB-1:0][DW-1:0] pwdata_o, prdata_i;
  logic [NB-1:0]         pready_i, pslverr_i;
  logic                  decerr_o, timeout_o;
  node_state_e           state_o;

  apb_node_ctrl #(
    .NB_MASTER      (NB),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .up           (up_if.slave),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i),
    .START_ADDR_i (start_addr),
    .END_ADDR_i   (end_addr),
    .decerr_o     (decerr_o),
    .timeout_o    (timeout_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {timeout, decerr, pslverr, prdata}
  logic [DW+2:0] exp_q[$];
  logic [DW+2:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave models ----------------
  int            wait_cfg[NB];
  int            wctr[NB];
  logic [NB-1:0] stray;

  initial begin
    pready_i = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        if (psel_o[i] && penable_o[i]) begin
          pready_i[i] = (wctr[i] >= wait_cfg[i]);
          wctr[i]++;
        end else begin
          wctr[i]     = 0;
          pready_i[i] = stray[i];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    wait (rst == 1'b0);
    forever begin
      @(negedge clk);
      if (up_if.pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pready: actual pready=1 required no response pending");
        end else begin
          mon_e = exp_q.pop_front();
          check("resp{to,dec,err,rdata}", {timeout_o, decerr_o, up_if.pslverr, up_if.prdata}, mon_e);
        end
      end else begin
        check("prdata_zero_when_not_ready", up_if.prdata, '0);
      end
    end
  end

  // ---------------- driver ----------------
  logic [NB-1:0]         psel_h[64], pen_h[64], pwr_h[64];
  logic [NB-1:0][AW-1:0] paddr_h[64];
  logic [NB-1:0][DW-1:0] pwdata_h[64];
  int                    pen_cnt;
  int                    lat;

  // Issues one transfer; setup is driven in cycle T, lat is the cycle
  // offset at which pready_o was seen. Returns at the negedge of RESP.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input logic [DW+2:0] exp);
    exp_q.push_back(exp);
    for (int k = 0; k < 64; k++) begin
      psel_h[k] = '0; pen_h[k] = '0; pwr_h[k] = '0; paddr_h[k] = '0; pwdata_h[k] = '0;
    end
    @(posedge clk); #1;
    up_if.psel    = 1'b1;
    up_if.penable = 1'b0;
    up_if.paddr   = addr;
    up_if.pwrite  = wr;
    up_if.pwdata  = wdata;
    pen_cnt = 0;
    lat     = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      up_if.penable = 1'b1;
      @(negedge clk);
      psel_h[n]   = psel_o;
      pen_h[n]    = penable_o;
      pwr_h[n]    = pwrite_o;
      paddr_h[n]  = paddr_o;
      pwdata_h[n] = pwdata_o;
      if (penable_o != '0) pen_cnt++;
      if (up_if.pready === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_bound: no pready within 60 cycles for addr 0x%0h", addr);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    up_if.psel    = 1'b0;
    up_if.penable = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    up_if.psel = 1'b0; up_if.penable = 1'b0; up_if.pwrite = 1'b0;
    up_if.paddr = '0;  up_if.pwdata = '0;
    for (int i = 0; i < NB; i++) begin
      start_addr[i] = AW'(32'h1000 * (i + 1));
      end_addr[i]   = AW'(32'h1000 * (i + 1) + 32'hFFF);
      wait_cfg[i]   = 0;
      wctr[i]       = 0;
    end
    prdata_i[0] = 32'h1234_5678;
    prdata_i[1] = 32'h1111_1111;
    prdata_i[2] = 32'h2222_2222;
    prdata_i[3] = 32'hA5A5_0003;
    pslverr_i = '0;
    stray     = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    // Reset state
    check("rst_pready", up_if.pready, 0);
    check("rst_pslverr", up_if.pslverr, 0);
    check("rst_prdata", up_if.prdata, 0);
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_pwrite", pwrite_o, 0);
    for (int i = 0; i < NB; i++) check("rst_paddr", paddr_o[i], 0);
    check("rst_decerr", decerr_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_state", state_o, ST_IDLE);

    // Zero-wait write to slave1
    do_xfer(32'h2004, 1'b1, 32'hDEAD_BEEF, {3'b000, 32'h0});
    check("wr_lat", lat, 3);
    check("wr_psel_t1", psel_h[1], 4'b0010);
    check("wr_pen_t1", pen_h[1], 4'b0000);
    check("wr_psel_t2", psel_h[2], 4'b0010);
    check("wr_pen_t2", pen_h[2], 4'b0010);
    check("wr_pwrite_t2", pwr_h[2], 4'b0010);
    check("wr_pwdata1_t2", pwdata_h[2][1], 32'hDEAD_BEEF);
    check("wr_paddr1_t2", paddr_h[2][1], 32'h2004);
    for (int i = 0; i < NB; i++) begin
      if (i != 1) begin
        check("wr_other_paddr", paddr_h[2][i], 0);
        check("wr_other_pwdata", pwdata_h[2][i], 0);
      end
    end
    check("wr_psel_resp", psel_h[3], 4'b0000);

    // Back-to-back read from slave0 with 3 wait states
    wait_cfg[0] = 3;
    do_xfer(32'h1010, 1'b0, 32'h0, {3'b000, 32'h1234_5678});
    check("rd_wait3_lat", lat, 6);
    check("rd_psel_t1", psel_h[1], 4'b0001);
    check("rd_pwrite_t2", pwr_h[2], 4'b0000);
    go_idle();

    // Unmapped address
    do_xfer(32'h9000, 1'b0, 32'h0, {3'b011, 32'h0});
    check("decerr_lat", lat, 1);
    check("decerr_no_psel", psel_h[1], 4'b0000);
    go_idle();

    // Slave2 never ready -> timeout
    wait_cfg[2] = 1000;
    do_xfer(32'h3004, 1'b0, 32'h0, {3'b101, 32'h0});
    check("to_lat", lat, TO + 2);
    check("to_penable_cycles", pen_cnt, TO);
    check("to_pen_last", pen_h[TO + 1], 4'b0100);
    check("to_psel_dropped", psel_h[TO + 2], 4'b0000);

    // Following transfer completes normally (back-to-back)
    do_xfer(32'h4000, 1'b0, 32'h0, {3'b000, 32'hA5A5_0003});
    check("after_to_lat", lat, 3);

    // Slave error on a read at the inclusive upper window edge
    wait_cfg[1]  = 2;
    pslverr_i[1] = 1'b1;
    do_xfer(32'h2FFF, 1'b0, 32'h0, {3'b001, 32'h0});
    check("slverr_lat", lat, 5);
    check("slverr_psel", psel_h[1], 4'b0010);
    go_idle();
    pslverr_i[1] = 1'b0;

    // Just below the first window
    do_xfer(32'h0FFF, 1'b0, 32'h0, {3'b011, 32'h0});
    check("below_lat", lat, 1);
    go_idle();

    // Overlapping windows; slave2 raises pready while unselected
    start_addr[0] = 32'h0000; end_addr[0] = 32'h3FFF;
    start_addr[2] = 32'h3000; end_addr[2] = 32'h3FFF;
    wait_cfg[0] = 2;
    wait_cfg[2] = 0;
    stray       = 4'b0100;
    do_xfer(32'h3000, 1'b0, 32'h0, {3'b000, 32'h1234_5678});
    check("ovl_lat", lat, 5);
    check("ovl_psel_t1", psel_h[1], 4'b0001);
    check("ovl_pen_t2", pen_h[2], 4'b0001);
    go_idle();
    stray = '0;

    // Reset while in ACCESS
    wait_cfg[0] = 1000;
    @(posedge clk); #1;
    up_if.psel = 1'b1; up_if.penable = 1'b0; up_if.paddr = 32'h1000; up_if.pwrite = 1'b0;
    @(posedge clk); #1;
    up_if.penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_access", penable_o, 4'b0001);
    @(posedge clk); #1;
    rst = 1'b0;
    up_if.psel = 1'b0; up_if.penable = 1'b0;
    @(negedge clk);
    check("abort_psel", psel_o, 0);
    check("abort_penable", penable_o, 0);
    check("abort_pready", up_if.pready, 0);
    check("abort_paddr0", paddr_o[0], 0);
    check("abort_state", state_o, ST_IDLE);
    wait_cfg[0] = 0;
    do_xfer(32'h1000, 1'b0, 32'h0, {3'b000, 32'h1234_5678});
    check("post_rst_lat", lat, 3);
    go_idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_node_ctrl.md
# apb_node_ctrl

Registered, parametrised APB fan-out node that sits between a single APB master (the bus bridge) and NB_MASTER peripheral slaves. Each transfer runs through a state machine. The node adds:
- an explicit upstream PSEL;
- configurable address and data widths;
- lowest-index priority when address windows overlap;
- a decode-error response for unmapped addresses;
- a per-transfer timeout that aborts a hung slave.

## Interface
Reset is synchronous and active-high on rst_i, in the single clock domain clk_i.

Parameters:
- NB_MASTER, 8, number of downstream slaves (1..32)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables timeout
- CNT_WIDTH, derived, $clog2(TIMEOUT_CYCLES+1), timeout counter width (not user-set)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- psel_i / penable_i / pwrite_i  in  1 each  upstream APB control
- paddr_i  in  APB_ADDR_WIDTH  upstream address
- pwdata_i  in  APB_DATA_WIDTH  upstream write data
- prdata_o  out  APB_DATA_WIDTH  read data to master
- pready_o / pslverr_o  out  1 each  response to master
- psel_o / penable_o / pwrite_o  out  NB_MASTER  per-slave control
- paddr_o  out  NB_MASTER x APB_ADDR_WIDTH  per-slave address
- pwdata_o  out  NB_MASTER x APB_DATA_WIDTH  per-slave write data
- prdata_i  in  NB_MASTER x APB_DATA_WIDTH  per-slave read data
- pready_i / pslverr_i  in  NB_MASTER  per-slave response
- START_ADDR_i / END_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive window per slave
- decerr_o / timeout_o  out  1 each  one-cycle status pulses

## Operation
States: IDLE, SETUP, ACCESS, RESP.

IDLE:
- On psel_i & !penable_i, latch paddr_i, pwdata_i, pwrite_i and the decode result.
- Decode: START ≤ addr ≤ END. The lowest matching index wins.
- If a slave matches, go to SETUP.
- If no slave matches, go to RESP with the error flag set and pulse decerr_o.

SETUP (one cycle):
- psel_o[idx]=1, penable_o=0.
- paddr_o, pwdata_o and pwrite_o of idx carry the latched values. All other slaves' outputs are 0.
- Go to ACCESS.

ACCESS:
- psel_o[idx]=1, penable_o[idx]=1.
- When pready_i[idx]=1, capture prdata_i[idx] and pslverr_i[idx], then go to RESP.
- The counter starts at 0 on entry and increments each cycle pready_i[idx]=0.
- If the counter equals TIMEOUT_CYCLES-1 and pready_i[idx]=0:
  - drop psel_o and penable_o;
  - go to RESP with pslverr set and prdata 0;
  - pulse timeout_o.

RESP (exactly one cycle):
- pready_o=1; pslverr_o and prdata_o come from the captured registers.
- Go to IDLE.

General rules:
- Upstream inputs are ignored outside IDLE. The latched copies are authoritative.
- prdata_o=0 whenever pready_o=0.
- prdata_o=0 on a write or an error response.
- A slave asserting pready_i while unselected has no effect.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from slave inputs to upstream outputs.
- Reset: all outputs 0, state IDLE, counter 0, latches 0.
- rst_i mid-transfer aborts without any pready_o; outputs are 0 on the next cycle.
- Upstream setup at cycle T: SETUP at T+1, ACCESS at T+2.
- A zero-wait slave gives pready_o at T+3; each slave wait state adds one cycle.
- Decode error: pready_o=1 and pslverr_o=1 at T+1.
- Timeout: penable_o high for exactly TIMEOUT_CYCLES cycles, RESP on the next cycle.
- Back-to-back: a new setup is accepted in the cycle after RESP.

## Structure
- Package apb_node_pkg holds the state enum typedef and the response-struct typedef (rdata, slverr).
- Sub-module apb_addr_decoder is combinational. It takes the address and windows and outputs a one-hot vector, a match flag and an index, with lowest-index priority.

## Test plan
- NB_MASTER=4, windows 0x1000–0x1FFF, 0x2000–0x2FFF, 0x3000–0x3FFF, 0x4000–0x4FFF. Write 0xDEADBEEF to 0x2004, zero-wait slave:
  - psel_o=4'b0010 at T+1;
  - penable_o[1] at T+2 with pwdata_o[1]=0xDEADBEEF;
  - pready_o at T+3 with pslverr_o=0;
  - all other slaves' outputs 0.
- Read 0x1010 with slave0 3 wait states and prdata_i[0]=0x12345678 -> pready_o at T+6 with prdata_o=0x12345678.
- Access to unmapped 0x9000 -> no psel_o; at T+1 pready_o=1, pslverr_o=1, prdata_o=0, decerr_o pulse.
- TIMEOUT_CYCLES=8, slave never ready:
  - penable_o[idx] high for 8 cycles;
  - then pready_o=1, pslverr_o=1, timeout_o pulse;
  - the following transfer completes normally.
- Windows overlap at 0x3000 (slave0 0x0000–0x3FFF, slave2 0x3000–0x3FFF) -> only psel_o[0] asserts.
- rst_i asserted in ACCESS -> all outputs 0 on the next cycle, no pready_o, and a new setup is accepted in the cycle after rst_i deasserts.
